// File: rtl/medidor_periodo_clk.sv
// medidor_periodo_clk
// Measures the period and high time of a slow asynchronous signal in units of
// clk_in cycles, strobes periodo_valido for one cycle on every new result and
// raises a sticky sin_senal flag when no rising edge arrives within TIMEOUT cycles.
module medidor_periodo_clk #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             activar,
  input  logic             sig_in,
  output logic [CNT_W-1:0] periodo,
  output logic [CNT_W-1:0] alto,
  output logic             periodo_valido,
  output logic             sin_senal
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMADO   = 2'd1,
    MIDIENDO = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic             s1, s2, s3;
  logic             rise, fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] alto_tmp_q, alto_tmp_d;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] periodo_d, alto_d;
  logic             valido_d, sin_d;
  logic             timeout_hit;

  // Two-flop synchroniser plus one delay stage so edges can be detected safely.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise        = s2 & ~s3;
  assign fall        = ~s2 & s3;
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  // Next-state and next-value logic; a rise always takes priority over a timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    alto_tmp_d  = alto_tmp_q;
    fall_seen_d = fall_seen_q;
    periodo_d   = periodo;
    alto_d      = alto;
    valido_d    = 1'b0;
    sin_d       = sin_senal;
    if (!activar) begin
      state_d = IDLE;
      cnt_d   = '0;
      sin_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          sin_d   = 1'b0;
          state_d = ARMADO;
        end
        ARMADO: begin
          if (rise) begin
            state_d     = MIDIENDO;
            cnt_d       = '0;
            fall_seen_d = 1'b0;
          end else if (timeout_hit) begin
            sin_d = 1'b1;
            cnt_d = '0;
          end
        end
        MIDIENDO: begin
          if (rise) begin
            periodo_d   = cnt_inc;
            alto_d      = fall_seen_q ? alto_tmp_q : '0;
            valido_d    = 1'b1;
            sin_d       = 1'b0;
            cnt_d       = '0;
            fall_seen_d = 1'b0;
          end else if (timeout_hit) begin
            sin_d   = 1'b1;
            cnt_d   = '0;
            state_d = ARMADO;
          end else if (fall) begin
            alto_tmp_d  = cnt_inc;
            fall_seen_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      alto_tmp_q     <= '0;
      fall_seen_q    <= 1'b0;
      periodo        <= '0;
      alto           <= '0;
      periodo_valido <= 1'b0;
      sin_senal      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alto_tmp_q     <= alto_tmp_d;
      fall_seen_q    <= fall_seen_d;
      periodo        <= periodo_d;
      alto           <= alto_d;
      periodo_valido <= valido_d;
      sin_senal      <= sin_d;
    end
  end

endmodule

// File: tb/tb_medidor_periodo_clk.sv
// Testbench for medidor_periodo_clk: timestamp-based reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_medidor_periodo_clk;

  localparam int CNT_W   = 26;
  localparam int TIMEOUT = 100;

  logic             clk_in;
  logic             reset;
  logic             activar;
  logic             sig_in;
  logic [CNT_W-1:0] periodo;
  logic [CNT_W-1:0] alto;
  logic             periodo_valido;
  logic             sin_senal;

  int checks = 0;
  int errors = 0;

  medidor_periodo_clk #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .activar       (activar),
    .sig_in        (sig_in),
    .periodo       (periodo),
    .alto          (alto),
    .periodo_valido(periodo_valido),
    .sin_senal     (sin_senal)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: edge timestamps instead of counters.
  // A level sampled on edge k is acted on at edge k+2 (two sync stages).
  int     n = 0;
  int     m_state = 0;
  int     ref_e = 0;
  int     rise_e = 0;
  int     fall_e = 0;
  bit     fall_seen = 0;
  bit     hist [4];
  longint m_periodo = 0;
  longint m_alto = 0;
  bit     m_valid = 0;
  bit     m_sin = 0;

  initial begin
    forever begin
      @(posedge clk_in or posedge reset);
      if (reset) begin
        for (int i = 0; i < 4; i++) hist[i] = 0;
        m_state = 0; ref_e = n; fall_seen = 0;
        m_periodo = 0; m_alto = 0; m_valid = 0; m_sin = 0;
      end else begin
        bit r, f;
        n++;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
        r = hist[2] && !hist[3];
        f = !hist[2] && hist[3];
        m_valid = 0;
        if (!activar) begin
          m_state = 0; ref_e = n; m_sin = 0;
        end else if (m_state == 0) begin
          m_state = 1; ref_e = n; m_sin = 0;
        end else if (m_state == 1) begin
          if (r) begin
            m_state = 2; rise_e = n; ref_e = n; fall_seen = 0;
          end else if (n - ref_e == TIMEOUT) begin
            m_sin = 1; ref_e = n;
          end
        end else begin
          if (r) begin
            m_periodo = n - rise_e;
            m_alto    = fall_seen ? (fall_e - rise_e) : 0;
            m_valid = 1; m_sin = 0;
            rise_e = n; ref_e = n; fall_seen = 0;
          end else if (n - ref_e == TIMEOUT) begin
            m_sin = 1; ref_e = n; m_state = 1;
          end else if (f) begin
            fall_e = n; fall_seen = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model plus strobe/timeout bookkeeping.
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;
  int prev_strobe_cyc = -1;
  int sin_rise_cyc = -1;
  bit sin_prev = 0;

  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      checkOutput("periodo", periodo, m_periodo);
      checkOutput("alto", alto, m_alto);
      checkOutput("periodo_valido", periodo_valido, m_valid);
      checkOutput("sin_senal", sin_senal, m_sin);
      if (periodo_valido === 1'b1) begin
        strobe_cnt++;
        prev_strobe_cyc = last_strobe_cyc;
        last_strobe_cyc = cyc;
      end
      if (sin_senal === 1'b1 && !sin_prev) sin_rise_cyc = cyc;
      sin_prev = (sin_senal === 1'b1);
    end
  end

  // Drives whole periods of sig_in; called on a falling edge.
  task automatic applyStimulus(input int high_len, input int low_len, input int periods);
    for (int p = 0; p < periods; p++) begin
      sig_in = 1'b1;
      repeat (high_len) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (low_len) @(negedge clk_in);
    end
  endtask

  task automatic goIdle();
    activar = 1'b0;
    sig_in  = 1'b0;
    repeat (6) @(negedge clk_in);
    activar = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  int base;

  initial begin
    reset = 1'b1; activar = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_periodo", periodo, 0);
    checkOutput("reset_alto", alto, 0);
    checkOutput("reset_valido", periodo_valido, 0);
    checkOutput("reset_sin", sin_senal, 0);
    reset = 1'b0;

    $display("[TB] square wave 10/5");
    goIdle();
    base = strobe_cnt;
    applyStimulus(5, 5, 5);
    repeat (4) @(negedge clk_in);
    checkOutput("t1_strobes", strobe_cnt - base, 4);
    checkOutput("t1_periodo", periodo, 10);
    checkOutput("t1_alto", alto, 5);
    checkOutput("t1_spacing", last_strobe_cyc - prev_strobe_cyc, 10);

    $display("[TB] minimum-width wave 2/2");
    goIdle();
    base = strobe_cnt;
    applyStimulus(2, 2, 6);
    repeat (4) @(negedge clk_in);
    checkOutput("t2_strobes", strobe_cnt - base, 5);
    checkOutput("t2_periodo", periodo, 4);
    checkOutput("t2_alto", alto, 2);
    checkOutput("t2_spacing", last_strobe_cyc - prev_strobe_cyc, 4);

    $display("[TB] timeout and recovery");
    goIdle();
    applyStimulus(5, 5, 3);
    repeat (120) @(negedge clk_in);
    checkOutput("t3_sin_set", sin_senal, 1);
    checkOutput("t3_timeout_delay", sin_rise_cyc - last_strobe_cyc, 100);
    checkOutput("t3_periodo_hold", periodo, 10);
    base = strobe_cnt;
    applyStimulus(6, 6, 3);
    repeat (4) @(negedge clk_in);
    checkOutput("t3_strobes", strobe_cnt - base, 2);
    checkOutput("t3_sin_clear", sin_senal, 0);
    checkOutput("t3_periodo", periodo, 12);

    $display("[TB] activar dropped mid-period");
    sig_in = 1'b0;
    repeat (120) @(negedge clk_in);
    checkOutput("t4_sin_before", sin_senal, 1);
    applyStimulus(4, 4, 2);
    sig_in = 1'b1;
    repeat (2) @(negedge clk_in);
    base = strobe_cnt;
    activar = 1'b0;
    repeat (2) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (6) @(negedge clk_in);
    checkOutput("t4_sin_idle", sin_senal, 0);
    activar = 1'b1;
    applyStimulus(4, 4, 3);
    repeat (4) @(negedge clk_in);
    checkOutput("t4_strobes", strobe_cnt - base, 2);
    checkOutput("t4_periodo", periodo, 8);

    $display("[TB] asynchronous reset mid-measurement");
    applyStimulus(3, 5, 2);
    sig_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_periodo", periodo, 0);
    checkOutput("t5_alto", alto, 0);
    checkOutput("t5_valido", periodo_valido, 0);
    checkOutput("t5_sin", sin_senal, 0);
    @(negedge clk_in);
    sig_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    base = strobe_cnt;
    applyStimulus(3, 3, 3);
    repeat (4) @(negedge clk_in);
    checkOutput("t5_strobes", strobe_cnt - base, 2);
    checkOutput("t5_periodo_after", periodo, 6);
    checkOutput("t5_alto_after", alto, 3);

    $display("[TB] rise on the timeout cycle");
    goIdle();
    base = strobe_cnt;
    applyStimulus(50, 50, 1);
    applyStimulus(50, 10, 1);
    checkOutput("t6_strobes", strobe_cnt - base, 1);
    checkOutput("t6_periodo", periodo, 100);
    checkOutput("t6_alto", alto, 50);
    checkOutput("t6_sin", sin_senal, 0);

    repeat (3) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
